pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Registered program-counter unit for the single-cycle/multi-cycle CPU. Successor to the combinational next-PC adder.
- Holds the PC and computes the next PC from sequential, conditional-branch, jump and jump-register sources, with stall support.
- Adds a parametrised return-address stack (RAS) so that jal pushes a link address and jr can take its target from the stack.
- Sits between the control unit/ALU flags and the instruction memory address port.

Parameters:
- AW, 32, PC/address width in bits.
- BR_SHIFT, 0, log2 of the address increment per instruction (0 = word-addressed, increment 1; 2 = byte-addressed, increment 4). The branch offset is shifted left by this amount.
- RESET_PC, 0, PC value loaded on reset.
- TGT_W, 26, jump target field width.
- RAS_DEPTH, 4, number of return-address entries (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and suppress RAS updates this cycle.
- branch  in  1  current instruction is a conditional branch.
- br_cond  in  3  condition select: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ; 6–7 never taken.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result MSB (operand negative).
- imm16  in  16  branch offset in instructions.
- jump  in  1  absolute jump (j/jal).
- target  in  TGT_W  jump target field.
- link  in  1  push the link address onto the RAS (jal/jalr).
- jr  in  1  register-indirect jump.
- use_ras  in  1  with jr: take the target from the RAS top instead of jr_target.
- jr_target  in  AW  register value for jr.
- pc  out  AW  current PC (registered).
- pc_plus  out  AW  pc + (1<<BR_SHIFT); combinational; equals the link value.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, RAS count=0, pointer=0, all entries 0. Result: ras_empty=1, ras_full=0.
- Offset and targets:
  - offset = sign-extend(imm16) to AW, << BR_SHIFT.
  - br_target = pc_plus + offset, modulo 2^AW (wrap, no saturation).
  - j_target = {pc_plus[AW-1 : TGT_W+BR_SHIFT], target, BR_SHIFT zeros}.
- Branch taken:
  - BEQ: zero.
  - BNE: !zero.
  - BLEZ: zero|sign.
  - BGTZ: !zero&!sign.
  - BLTZ: sign.
  - BGEZ: !sign.
  - Taken only when branch=1.
- Next-PC priority: jr > jump > taken branch > pc_plus.
  - jr target = RAS top if (use_ras & !ras_empty), else jr_target.
  - use_ras with an empty RAS falls back to jr_target silently.
- Latency: pc updates on the rising edge after the inputs are presented; one instruction per cycle.
- stall=1: pc holds, RAS unchanged, all control inputs ignored. pc_plus still reflects the held pc.
- RAS is a circular LIFO:
  - Pop: occurs when jr & use_ras & !ras_empty & !stall. The pointer is decremented and count decremented.
  - Push: occurs when link & !stall. Writes pc_plus at the pointer, then increments the pointer and count.
  - Push when full: overwrites the oldest entry (pointer wraps); count stays RAS_DEPTH.
  - Simultaneous pop and push (jalr via RAS): the target is the pre-update top; the top entry is replaced with pc_plus; count unchanged.
  - Pop when empty: no change.
- Illegal combination jump & jr: jr wins (priority); no error flag.
- Reset mid-stall or mid-operation: async reset overrides everything immediately.

Decomposition:
- Shared package cpu_pkg:
  - br_cond encodings: BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ.
  - Default AW and RESET_PC constants.
- One sub-module, ras_stack:
  - Parameters: AW, RAS_DEPTH.
  - Ports: push, pop, din, top, empty, full.
  - pc_unit holds the PC register and the next-PC mux.

Test Plan:
1. Reset → pc=0, ras_empty=1. Then 3 idle cycles → pc=1,2,3 (BR_SHIFT=0).
2. pc=10, branch=1, br_cond=BNE, zero=0, imm16=16'hFFFC → pc=7. Same with zero=1 → pc=11.
3. pc=10, jump=1, link=1, target=26'h40 → pc=0x40, RAS top=11. Later at pc=0x45, jr=1, use_ras=1 → pc=11, ras_empty=1.
4. RAS_DEPTH=4: five pushes of 1..5 (with stall=0), then four pops → targets 5,4,3,2. ras_full was 1 after the 4th push. A fifth pop falls back to jr_target=0x99.
5. stall=1 with jump=1, link=1 for 2 cycles → pc unchanged, RAS count unchanged. Release stall → jump taken.
6. pc=0xFFFFFFFF, BR_SHIFT=0, no branch → pc wraps to 0. rst_n pulsed low mid-cycle → pc=RESET_PC immediately, RAS empty.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the program-counter unit.
//   - Branch condition encodings carried on br_cond.
//   - Default address width and reset PC.
//   - branch_taken(): evaluates a branch condition against the ALU flags.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LEZ = 3'd2,
    BR_GTZ = 3'd3,
    BR_LTZ = 3'd4,
    BR_GEZ = 3'd5
  } br_cond_e;

  localparam int unsigned DEFAULT_AW       = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

  // Encodings 6 and 7 are reserved and never taken.
  function automatic logic branch_taken(input logic [2:0] cond, input logic zero,
                                        input logic sign);
    logic taken;
    taken = 1'b0;
    case (cond)
      BR_EQ:   taken = zero;
      BR_NE:   taken = !zero;
      BR_LEZ:  taken = zero | sign;
      BR_GTZ:  taken = !zero & !sign;
      BR_LTZ:  taken = sign;
      BR_GEZ:  taken = !sign;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: a circular LIFO of RAS_DEPTH entries.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push        write din on top of the stack (overwrites oldest entry when full)
//   pop         remove the top entry (ignored when empty)
//   din         value to push
//   top         current top entry (most recent push)
//   empty/full  occupancy flags
// push and pop together replace the top entry in place; count is unchanged.
module ras_stack #(
  parameter int unsigned AW        = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q;    // next free slot
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] top_idx;
  logic          do_pop;

  // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
  assign top_idx = ptr_q - PW'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign do_pop  = pop & !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push && do_pop) begin
      mem_q[top_idx] <= din;
    end else if (push) begin
      mem_q[ptr_q] <= din;
      ptr_q        <= ptr_q + PW'(1);
      if (!full) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (do_pop) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Registered program-counter unit with return-address stack.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   stall           hold pc and the RAS this cycle
//   branch, br_cond conditional branch and its condition (cpu_pkg::br_cond_e)
//   zero, sign      ALU flags
//   imm16           branch offset in instructions
//   jump, target    absolute jump and its target field
//   link            push pc_plus onto the RAS
//   jr, use_ras     register-indirect jump; use_ras takes the target from the RAS
//   jr_target       register value for jr
//   pc, pc_plus     current PC and its sequential successor (link value)
//   ras_empty/full  RAS occupancy
// Next-PC priority: jr > jump > taken branch > pc_plus.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned   AW        = DEFAULT_AW,
  parameter int unsigned   BR_SHIFT  = 0,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter int unsigned   TGT_W     = 26,
  parameter int unsigned   RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch,
  input  logic [2:0]       br_cond,
  input  logic             zero,
  input  logic             sign,
  input  logic [15:0]      imm16,
  input  logic             jump,
  input  logic [TGT_W-1:0] target,
  input  logic             link,
  input  logic             jr,
  input  logic             use_ras,
  input  logic [AW-1:0]    jr_target,
  output logic [AW-1:0]    pc,
  output logic [AW-1:0]    pc_plus,
  output logic             ras_empty,
  output logic             ras_full
);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] offset;
  logic [AW-1:0] br_target;
  logic [AW-1:0] j_target;
  logic [AW-1:0] jr_dest;
  logic [AW-1:0] ras_top;
  logic [AW-1:0] hi_mask;
  logic          taken;
  logic          ras_push;
  logic          ras_pop;

  assign pc      = pc_q;
  assign pc_plus = pc_q + (AW'(1) << BR_SHIFT);

  assign offset    = {{(AW-16){imm16[15]}}, imm16} << BR_SHIFT;
  assign br_target = pc_plus + offset;

  // Keep the upper pc_plus bits above the target field; built with masks so
  // that BR_SHIFT = 0 needs no zero-width concatenation.
  assign hi_mask  = ~((AW'(1) << (TGT_W + BR_SHIFT)) - AW'(1));
  assign j_target = (pc_plus & hi_mask) | (AW'(target) << BR_SHIFT);

  assign taken   = branch & branch_taken(br_cond, zero, sign);
  assign jr_dest = (use_ras && !ras_empty) ? ras_top : jr_target;

  assign ras_push = link & !stall;
  assign ras_pop  = jr & use_ras & !ras_empty & !stall;

  always_comb begin
    pc_d = pc_plus;
    if (stall) begin
      pc_d = pc_q;
    end else if (jr) begin
      pc_d = jr_dest;
    end else if (jump) begin
      pc_d = j_target;
    end else if (taken) begin
      pc_d = br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  ras_stack #(
    .AW       (AW),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .rst_n(rst_n),
    .push (ras_push),
    .pop  (ras_pop),
    .din  (pc_plus),
    .top  (ras_top),
    .empty(ras_empty),
    .full (ras_full)
  );

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, zero, sign, jump, link, jr, use_ras;
  logic [2:0]  br_cond;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] jr_target;
  logic [31:0] pc, pc_plus;
  logic        ras_empty, ras_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .branch   (branch),
    .br_cond  (br_cond),
    .zero     (zero),
    .sign     (sign),
    .imm16    (imm16),
    .jump     (jump),
    .target   (target),
    .link     (link),
    .jr       (jr),
    .use_ras  (use_ras),
    .jr_target(jr_target),
    .pc       (pc),
    .pc_plus  (pc_plus),
    .ras_empty(ras_empty),
    .ras_full (ras_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    stall = 0; branch = 0; br_cond = 3'd0; zero = 0; sign = 0; imm16 = 16'h0;
    jump = 0; target = 26'h0; link = 0; jr = 0; use_ras = 0; jr_target = 32'h0;
  endtask

  // Expected next pc is queued when the stimulus is driven, then popped and
  // compared once the clock edge has produced the DUT result.
  task automatic tick(input string tag, input logic [31:0] expv);
    logic [31:0] e;
    string       t;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, pc, e);
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    idle();
    jr = 1; jr_target = addr;
    tick("goto", addr);
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    check("reset_pc", pc, 32'h0);
    check("reset_empty", 32'(ras_empty), 32'h1);
    check("reset_full", 32'(ras_full), 32'h0);
    rst_n = 1;

    // Sequential flow
    tick("seq1", 32'd1);
    tick("seq2", 32'd2);
    tick("seq3", 32'd3);

    // Branch conditions
    goto_pc(32'd10);
    branch = 1; br_cond = BR_NE; zero = 0; imm16 = 16'hFFFC;
    tick("bne_taken", 32'd7);
    goto_pc(32'd10);
    branch = 1; br_cond = BR_NE; zero = 1; imm16 = 16'hFFFC;
    tick("bne_not_taken", 32'd11);
    branch = 1; br_cond = BR_LEZ; zero = 0; sign = 1; imm16 = 16'd5;
    tick("blez_sign", 32'd17);
    branch = 1; br_cond = BR_GTZ; zero = 0; sign = 0; imm16 = 16'd2;
    tick("bgtz", 32'd20);
    branch = 1; br_cond = BR_LTZ; zero = 0; sign = 0; imm16 = 16'd8;
    tick("bltz_not_taken", 32'd21);
    branch = 1; br_cond = BR_GEZ; zero = 0; sign = 0; imm16 = 16'h0010;
    tick("bgez", 32'd38);
    branch = 1; br_cond = 3'd6; zero = 1; sign = 1; imm16 = 16'd4;
    tick("cond6_never", 32'd39);
    branch = 0; br_cond = BR_EQ; zero = 1; imm16 = 16'd4;
    tick("beq_no_branch", 32'd40);
    idle();

    // jal / jr via RAS
    goto_pc(32'd10);
    jump = 1; link = 1; target = 26'h40;
    tick("jal", 32'h40);
    check("jal_not_empty", 32'(ras_empty), 32'h0);
    idle();
    for (int i = 1; i <= 5; i++) tick("seq_after_jal", 32'h40 + 32'(i));
    jr = 1; use_ras = 1; jr_target = 32'h123;
    tick("jr_ras", 32'd11);
    check("jr_ras_empty", 32'(ras_empty), 32'h1);
    idle();

    // Five pushes into a depth-4 stack, then pops
    goto_pc(32'd0);
    link = 1;
    for (int i = 1; i <= 5; i++) begin
      tick("push", 32'(i));
      if (i == 4) check("full_after_4", 32'(ras_full), 32'h1);
    end
    check("full_after_5", 32'(ras_full), 32'h1);
    idle();
    jr = 1; use_ras = 1; jr_target = 32'h99;
    tick("pop5", 32'd5);
    check("not_full_after_pop", 32'(ras_full), 32'h0);
    tick("pop4", 32'd4);
    tick("pop3", 32'd3);
    tick("pop2", 32'd2);
    check("empty_after_4_pops", 32'(ras_empty), 32'h1);
    tick("pop_empty_fallback", 32'h99);
    idle();

    // jump & jr together: jr wins
    jump = 1; target = 26'h7; jr = 1; jr_target = 32'h30;
    tick("jr_over_jump", 32'h30);
    idle();

    // Stall holds pc and RAS
    stall = 1; jump = 1; link = 1; target = 26'h80;
    tick("stall1", 32'h30);
    tick("stall2", 32'h30);
    check("stall_ras_empty", 32'(ras_empty), 32'h1);
    check("stall_pc_plus", pc_plus, 32'h31);
    stall = 0;
    tick("stall_release", 32'h80);
    check("release_pushed", 32'(ras_empty), 32'h0);
    idle();

    // Simultaneous push and pop replaces the top entry
    jr = 1; use_ras = 1; link = 1; jr_target = 32'h55;
    tick("jalr_ras", 32'h31);
    check("jalr_count_kept", 32'(ras_empty), 32'h0);
    link = 0;
    tick("pop_replaced", 32'h81);
    check("pop_replaced_empty", 32'(ras_empty), 32'h1);
    idle();

    // Wrap and asynchronous reset
    goto_pc(32'hFFFF_FFFF);
    check("pc_plus_wrap", pc_plus, 32'h0);
    tick("pc_wrap", 32'h0);
    link = 1;
    tick("push_before_reset", 32'h1);
    stall = 1;
    #2;
    rst_n = 0;
    #1;
    check("async_reset_pc", pc, 32'h0);
    check("async_reset_empty", 32'(ras_empty), 32'h1);
    #2;
    rst_n = 1;
    idle();
    tick("after_reset", 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
